lsu_byte_initiator: RTL

Load/store initiator for the MEM stage of the pipelined MIPS core. Accepts one load or store request (byte, half or word) from the EX/MEM side. Serialises it into single-byte transactions on a byte-wide, big-endian data-memory port with one-cycle registered read latency. Returns the assembled, sign- or zero-extended load data, or a store completion, and stalls the pipeline while busy.

---
 rtl/lsu_byte_initiator_if.sv | 38 +++
 rtl/lsu_byte_initiator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_initiator_if.sv
// lsu_byte_initiator_if
// Groups the EX/MEM request/response handshake and the byte-wide
// data-memory port of the load/store initiator into one bundle.
// The master modport is taken by the initiator, which drives the memory
// port and answers requests. The slave modport is the environment side,
// meaning the pipeline stage plus the data memory.
interface lsu_byte_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall,
        output mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall,
        input  mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_byte_initiator.sv
// lsu_byte_initiator
// MEM-stage load/store initiator. It breaks a byte/half/word request into
// single-byte accesses on a big-endian byte memory with one-cycle read
// latency. It then returns either extended load data or a store completion.
// Optional feature macro: LSU_ERR_CHECK_EN. When it is defined, the block
// rejects misaligned, size-3 and out-of-range requests with resp_err. When
// it is undefined, addresses wrap modulo MEM_BYTES and size 3 acts as word.
module lsu_byte_initiator #(
    parameter int MEM_BYTES = 128
) (
    input  logic                  CLK,
    input  logic                  RST,
    lsu_byte_initiator_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] acc_q;
    logic [1:0]  last_q;
    logic [1:0]  cnt_q;
    logic        write_q;
    logic        unsigned_q;
    logic        rd_pend_q;
    logic        stall_q;

    logic        accept;
    logic [1:0]  req_last;
    logic        req_err;
    logic        resp_err_c;
    logic [31:0] issue_addr;
    logic [1:0]  byte_shift;
    logic [7:0]  store_byte;
    logic [31:0] load_ext;

    logic        mem_re_c;
    logic        mem_we_c;
    logic [31:0] mem_addr_c;
    logic [7:0]  mem_wdata_c;
    logic        resp_valid_c;
    logic [31:0] resp_rdata_c;

    assign accept = bus.req_valid && (state == IDLE);

    // Index of the last byte of the incoming request; size 3 maps to a word
    always_comb begin
        case (bus.req_size)
            2'd0:    req_last = 2'd0;
            2'd1:    req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
    end

`ifdef LSU_ERR_CHECK_EN
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    logic        err_q;
    logic [32:0] req_end;

    assign req_end = {1'b0, bus.req_addr} + 33'(req_last) + 33'd1;

    // Reject requests that are misaligned, of size 3, or run past the end of memory
    always_comb begin
        case (bus.req_size)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = bus.req_addr[0];
            2'd2:    req_err = (bus.req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if (req_end > MEM_LIMIT) begin
            req_err = 1'b1;
        end
    end

    // Remember whether the accepted request was rejected
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= req_err;
        end
    end

    assign resp_err_c = err_q;
    assign issue_addr = addr_q + 32'(cnt_q);
`else
    localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);

    assign req_err    = 1'b0;
    assign resp_err_c = 1'b0;
    assign issue_addr = (addr_q + 32'(cnt_q)) % MEM_SIZE;
`endif

    // Bytes leave MSB first, so byte i of the request is byte (last - i) from the LSB
    assign byte_shift = last_q - cnt_q;
    assign store_byte = wdata_q[{byte_shift, 3'b000} +: 8];

    // Extend the assembled load value from its top bit unless zero-extension was asked for
    always_comb begin
        case (last_q)
            2'd0:    load_ext = {{24{acc_q[7] & ~unsigned_q}}, acc_q[7:0]};
            2'd1:    load_ext = {{16{acc_q[15] & ~unsigned_q}}, acc_q[15:0]};
            default: load_ext = acc_q;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: walk the bytes, drain the final read, then respond once
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == last_q) begin
                    state_next = write_q ? RESP : DRAIN;
                end
            end
            DRAIN:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, byte counter, read accumulator and registered stall
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            acc_q      <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            stall_q   <= (state_next != IDLE);
            rd_pend_q <= mem_re_c;
            if (accept) begin
                addr_q     <= bus.req_addr;
                wdata_q    <= bus.req_wdata;
                last_q     <= req_last;
                write_q    <= bus.req_write;
                unsigned_q <= bus.req_unsigned;
                cnt_q      <= '0;
                acc_q      <= '0;
            end else begin
                if (state == ISSUE) begin
                    cnt_q <= cnt_q + 2'd1;
                end
                if (rd_pend_q) begin
                    acc_q <= {acc_q[23:0], bus.mem_rdata};
                end
            end
        end
    end

    // Output decode: memory strobes only in ISSUE, response fields only in RESP
    always_comb begin
        mem_re_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        resp_valid_c = 1'b0;
        resp_rdata_c = '0;
        case (state)
            ISSUE: begin
                mem_addr_c = issue_addr;
                if (write_q) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = store_byte;
                end else begin
                    mem_re_c = 1'b1;
                end
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (!write_q && !resp_err_c) begin
                    resp_rdata_c = load_ext;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.stall      = stall_q;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_rdata = resp_rdata_c;
    assign bus.resp_err   = resp_valid_c & resp_err_c;
    assign bus.mem_re     = mem_re_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;

endmodule
